// File: rtl/shift_counter_pkg.sv
// shift_counter_pkg: shared mode/direction constants and next-action selection
// for the multimode shift counter.
package shift_counter_pkg;
   localparam logic MODE_JOHNSON = 1'b0;
   localparam logic MODE_RING    = 1'b1;
   localparam logic DIR_LEFT     = 1'b0;
   localparam logic DIR_RIGHT    = 1'b1;

   typedef enum logic [1:0] {ACT_HOLD, ACT_LOAD, ACT_STEP, ACT_FIX} act_t;

   // load beats en; an enabled edge on an illegal pattern becomes a correction
   function automatic act_t pick_act(input logic load, input logic en, input logic legal);
      return load ? ACT_LOAD : en ? (legal ? ACT_STEP : ACT_FIX) : ACT_HOLD;
   endfunction
endpackage

// File: rtl/shift_counter_decode.sv
// shift_counter_decode: combinational legality check and sequence-position decode.
//   q         : current counter pattern
//   mode      : 0 Johnson, 1 ring
//   legal     : q is a member of the current mode's sequence
//   state_idx : position of q in the sequence (0 when illegal)
module shift_counter_decode #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0]            q,
   input  logic                        mode,
   output logic                        legal,
   output logic [$clog2(2*WIDTH)-1:0]  state_idx
);
   import shift_counter_pkg::*;

   localparam int IW = $clog2(2*WIDTH);

   logic [WIDTH-1:0] nq;
   logic             j_low;
   logic             j_high;
   logic             r_legal;
   int               pop;
   int               pos;

   assign nq = ~q;
   // a run of ones from bit 0 has no carry-free gap: q & (q+1) == 0
   assign j_low   = (q & (q + WIDTH'(1))) == '0;
   // a run of ones from bit W-1 is the same test on the complement
   assign j_high  = (nq & (nq + WIDTH'(1))) == '0;
   assign r_legal = (q != '0) && ((q & (q - WIDTH'(1))) == '0);

   always_comb begin
      pop = 0;
      pos = 0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + (q[i] ? 1 : 0);
         if (q[i]) pos = i;
      end
      legal     = (mode == MODE_RING) ? r_legal : (j_low | j_high);
      state_idx = !legal              ? '0 :
                  (mode == MODE_RING) ? IW'(pos) :
                  q[0]                ? IW'(pop) :
                  (q == '0)           ? '0 : IW'(2*WIDTH - pop);
   end
endmodule

// File: rtl/multimode_shift_counter.sv
// multimode_shift_counter: Johnson / one-hot ring counter with load, direction
// control and self-correction of illegal patterns.
//   clk, reset   : rising-edge clock, asynchronous active-low reset
//   en           : advance enable
//   mode, dir    : 0 Johnson / 1 ring, 0 left / 1 right
//   load,load_val: synchronous parallel load (highest priority)
//   q            : counter state
//   state_idx    : sequence position decoded from q
//   wrap         : one-cycle pulse after a normal step onto the start pattern
//   illegal      : one-cycle pulse after a correction
module multimode_shift_counter #(
   parameter int WIDTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en,
   input  logic                        mode,
   input  logic                        dir,
   input  logic                        load,
   input  logic [WIDTH-1:0]            load_val,
   output logic [WIDTH-1:0]            q,
   output logic [$clog2(2*WIDTH)-1:0]  state_idx,
   output logic                        wrap,
   output logic                        illegal
);
   import shift_counter_pkg::*;

   logic             legal;
   act_t             act;
   logic             fb;
   logic [WIDTH-1:0] start;
   logic [WIDTH-1:0] step;
   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;
   logic             illegal_nxt;

   shift_counter_decode #(.WIDTH(WIDTH)) u_decode (
      .q         (q),
      .mode      (mode),
      .legal     (legal),
      .state_idx (state_idx)
   );

   always_comb begin
      start       = (mode == MODE_RING) ? WIDTH'(1) : '0;
      // the bit rotated in is the outgoing end bit, inverted for Johnson
      fb          = ((dir == DIR_RIGHT) ? q[0] : q[WIDTH-1]) ^ (mode == MODE_JOHNSON);
      step        = (dir == DIR_RIGHT) ? {fb, q[WIDTH-1:1]} : {q[WIDTH-2:0], fb};
      act         = pick_act(load, en, legal);
      q_nxt       = (act == ACT_LOAD) ? load_val :
                    (act == ACT_STEP) ? step :
                    (act == ACT_FIX)  ? start : q;
      wrap_nxt    = (act == ACT_STEP) && (step == start);
      illegal_nxt = (act == ACT_FIX);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q       <= '0;
         wrap    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         q       <= q_nxt;
         wrap    <= wrap_nxt;
         illegal <= illegal_nxt;
      end
   end
endmodule
